// File: rtl/hamming_tx_sched_if.sv
// Handshake bundle for hamming_tx_sched.
//   req0_*/req1_* : two 64-bit requesters (valid/data in, ready out)
//   tx_*          : 16-bit codeword block stream (valid/data/last/src out, ready in)
//   busy          : scheduler is streaming a codeword
// slave  : seen from the scheduler
// master : seen from the requesters / downstream sink
interface hamming_tx_sched_if;
  logic        req0_valid;
  logic [63:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [63:0] req1_data;
  logic        req1_ready;
  logic        tx_valid;
  logic [15:0] tx_data;
  logic        tx_last;
  logic        tx_src;
  logic        tx_ready;
  logic        busy;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, tx_ready,
    output req0_ready, req1_ready, tx_valid, tx_data, tx_last, tx_src, busy
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, tx_ready,
    input  req0_ready, req1_ready, tx_valid, tx_data, tx_last, tx_src, busy
  );
endinterface

// File: rtl/hamming_tx_sched.sv
// Two-requester Hamming encoder/scheduler.
// A granted 64-bit word is encoded into eight 16-bit blocks (one per data
// byte) and streamed on tx_* one block per accepted beat.
// Block layout (bit 15..0): overall parity, p1, p2, d7, p4, d6..d4, p8,
// d3..d0, 3'b000 -- Hamming(12,8) positions 1..12 on bits 14..3.
// Ports: clk, rst_n (async, active low), bus (hamming_tx_sched_if.slave).
// Parameter MSB_FIRST: 0 sends block 0 first, 1 sends block 7 first.
// Macro HAMMING_TX_RR_EN: defined -> round-robin on ties, else req0 wins.

module encoder (
  input  logic [63:0]  data_in,
  output logic [127:0] code_out
);
  function automatic logic [15:0] enc_byte(input logic [7:0] d);
    logic p1, p2, p4, p8;
    p1 = d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
    p2 = d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
    p4 = d[6] ^ d[5] ^ d[4] ^ d[0];
    p8 = d[3] ^ d[2] ^ d[1] ^ d[0];
    return {p1 ^ p2 ^ p4 ^ p8 ^ (^d), p1, p2, d[7], p4, d[6:4], p8, d[3:0], 3'b000};
  endfunction

  always_comb begin
    code_out = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      code_out[16*k +: 16] = enc_byte(data_in[8*k +: 8]);
    end
  end
endmodule

module hamming_tx_sched #(
  parameter bit MSB_FIRST = 1'b0
) (
  input logic               clk,
  input logic               rst_n,
  hamming_tx_sched_if.slave bus
);
  typedef enum logic {IDLE, SEND} state_t;

  state_t       state;
  logic [127:0] codeword;
  logic [127:0] enc_out;
  logic [63:0]  enc_in;
  logic [2:0]   blk_cnt;
  logic [2:0]   blk_idx;
  logic         src_q;
  logic         grant0;
  logic         grant1;

  // Ready is combinational from the grant; gating with rst_n keeps both
  // ready lines low while reset is held.
`ifdef HAMMING_TX_RR_EN
  logic ptr;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE && rst_n) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant0 = ~ptr;
        grant1 = ptr;
      end else begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid;
      end
    end
  end
`else
  always_comb begin
    grant0 = (state == IDLE) && rst_n && bus.req0_valid;
    grant1 = (state == IDLE) && rst_n && bus.req1_valid && !bus.req0_valid;
  end
`endif

  assign enc_in = grant1 ? bus.req1_data : bus.req0_data;

  encoder u_encoder (
    .data_in  (enc_in),
    .code_out (enc_out)
  );

  assign blk_idx        = MSB_FIRST ? (3'd7 - blk_cnt) : blk_cnt;
  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.tx_valid   = (state == SEND);
  assign bus.busy       = (state == SEND);
  assign bus.tx_data    = codeword[{blk_idx, 4'b0000} +: 16];
  assign bus.tx_last    = (state == SEND) && (blk_cnt == 3'd7);
  assign bus.tx_src     = src_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      codeword <= '0;
      blk_cnt  <= '0;
      src_q    <= 1'b0;
`ifdef HAMMING_TX_RR_EN
      ptr      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            codeword <= enc_out;
            src_q    <= grant1;
            blk_cnt  <= '0;
            state    <= SEND;
`ifdef HAMMING_TX_RR_EN
            ptr      <= grant0;
`endif
          end
        end
        SEND: begin
          if (bus.tx_ready) begin
            blk_cnt <= blk_cnt + 3'd1;
            if (blk_cnt == 3'd7) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hamming_tx_sched.sv
// Self-checking bench for hamming_tx_sched: one LSB-first and one
// MSB-first instance driven with identical stimulus, scoreboard queues
// filled from an independent Hamming reference on every predicted grant.
module tb_hamming_tx_sched;
  typedef struct packed {
    logic [15:0] data;
    logic        last;
    logic        src;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hamming_tx_sched_if bus0 ();
  hamming_tx_sched_if bus1 ();

  assign bus1.req0_valid = bus0.req0_valid;
  assign bus1.req0_data  = bus0.req0_data;
  assign bus1.req1_valid = bus0.req1_valid;
  assign bus1.req1_data  = bus0.req1_data;
  assign bus1.tx_ready   = bus0.tx_ready;

  hamming_tx_sched #(.MSB_FIRST(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  hamming_tx_sched #(.MSB_FIRST(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int unsigned total = 0;
  int unsigned bad = 0;

  beat_t q0[$];
  beat_t q1[$];
  beat_t log0[$];
  beat_t log1[$];
  logic  glog[$];

  logic       m_busy = 1'b0;
  logic [2:0] m_cnt = '0;
`ifdef HAMMING_TX_RR_EN
  logic       m_ptr = 1'b0;
`endif
  logic       stall0 = 1'b0;
  beat_t      prev0;
  int unsigned ready_mode = 0;
  logic [1:0] pcnt = '0;
  logic [3:0] pat = 4'b1001;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: place byte bits d7..d0 on Hamming positions 3,5,6,7,9..12,
  // compute even parity on 1,2,4,8, map position p to bit 15-p, overall parity on bit 15.
  function automatic logic [15:0] ref_block(input logic [7:0] d);
    logic [12:0] pos;
    logic [15:0] b;
    logic        par;
    int          di;
    pos = '0;
    di  = 7;
    for (int unsigned p = 1; p <= 12; p++) begin
      if ((p & (p - 1)) != 0) begin
        pos[p] = d[di];
        di--;
      end
    end
    for (int unsigned k = 1; k <= 8; k = k * 2) begin
      par = 1'b0;
      for (int unsigned p = 1; p <= 12; p++) begin
        if ((p & k) != 0 && p != k) par ^= pos[p];
      end
      pos[k] = par;
    end
    b   = '0;
    par = 1'b0;
    for (int unsigned p = 1; p <= 12; p++) begin
      b[15 - p] = pos[p];
      par ^= pos[p];
    end
    b[15] = par;
    return b;
  endfunction

  task automatic push_word(input logic src, input logic [63:0] d);
    beat_t b;
    for (int unsigned i = 0; i < 8; i++) begin
      b.last = (i == 7);
      b.src  = src;
      b.data = ref_block(d[8*i +: 8]);
      q0.push_back(b);
    end
    for (int unsigned i = 0; i < 8; i++) begin
      b.last = (i == 7);
      b.src  = src;
      b.data = ref_block(d[8*(7-i) +: 8]);
      q1.push_back(b);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (ready_mode == 1) begin
      bus0.tx_ready = pat[pcnt];
      pcnt++;
    end else if (ready_mode == 2) begin
      bus0.tx_ready = 1'($urandom_range(0, 1));
    end else begin
      bus0.tx_ready = 1'b1;
      pcnt = '0;
    end
  end

  // Monitor / model, sampled on the falling edge.
  always @(negedge clk) begin
    logic v0, v1, win, e_r0, e_r1;
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      m_busy = 1'b0;
      m_cnt  = '0;
      stall0 = 1'b0;
`ifdef HAMMING_TX_RR_EN
      m_ptr  = 1'b0;
`endif
      check_eq("rst_tx_valid0", 64'(bus0.tx_valid), 64'(0));
      check_eq("rst_tx_valid1", 64'(bus1.tx_valid), 64'(0));
      check_eq("rst_ready0", 64'(bus0.req0_ready), 64'(0));
      check_eq("rst_ready1", 64'(bus0.req1_ready), 64'(0));
    end else begin
      v0 = bus0.req0_valid;
      v1 = bus0.req1_valid;
`ifdef HAMMING_TX_RR_EN
      win = (v0 && v1) ? m_ptr : v1;
`else
      win = v1 && !v0;
`endif
      e_r0 = !m_busy && v0 && !win;
      e_r1 = !m_busy && v1 && win;
      check_eq("req0_ready", 64'(bus0.req0_ready), 64'(e_r0));
      check_eq("req1_ready", 64'(bus0.req1_ready), 64'(e_r1));
      check_eq("req0_ready_m", 64'(bus1.req0_ready), 64'(e_r0));
      check_eq("req1_ready_m", 64'(bus1.req1_ready), 64'(e_r1));
      check_eq("ready_excl", 64'(bus0.req0_ready & bus0.req1_ready), 64'(0));
      if (bus0.req0_valid && bus0.req0_ready) glog.push_back(1'b0);
      if (bus0.req1_valid && bus0.req1_ready) glog.push_back(1'b1);
      check_eq("tx_valid0", 64'(bus0.tx_valid), 64'(m_busy));
      check_eq("busy0", 64'(bus0.busy), 64'(m_busy));
      check_eq("tx_valid1", 64'(bus1.tx_valid), 64'(m_busy));

      if (stall0 && bus0.tx_valid) begin
        check_eq("hold_data", 64'(bus0.tx_data), 64'(prev0.data));
        check_eq("hold_last", 64'(bus0.tx_last), 64'(prev0.last));
        check_eq("hold_src", 64'(bus0.tx_src), 64'(prev0.src));
      end
      stall0 = bus0.tx_valid && !bus0.tx_ready;
      prev0  = '{data: bus0.tx_data, last: bus0.tx_last, src: bus0.tx_src};

      if (bus0.tx_valid) begin
        check_eq("beat_pending0", 64'(q0.size() != 0), 64'(1));
        if (q0.size() != 0) begin
          check_eq("tx_data0", 64'(bus0.tx_data), 64'(q0[0].data));
          check_eq("tx_last0", 64'(bus0.tx_last), 64'(q0[0].last));
          check_eq("tx_src0", 64'(bus0.tx_src), 64'(q0[0].src));
          if (bus0.tx_ready) begin
            void'(q0.pop_front());
            log0.push_back(prev0);
          end
        end
      end
      if (bus1.tx_valid) begin
        check_eq("beat_pending1", 64'(q1.size() != 0), 64'(1));
        if (q1.size() != 0) begin
          check_eq("tx_data1", 64'(bus1.tx_data), 64'(q1[0].data));
          check_eq("tx_last1", 64'(bus1.tx_last), 64'(q1[0].last));
          check_eq("tx_src1", 64'(bus1.tx_src), 64'(q1[0].src));
          if (bus1.tx_ready) begin
            void'(q1.pop_front());
            log1.push_back('{data: bus1.tx_data, last: bus1.tx_last, src: bus1.tx_src});
          end
        end
      end

      if (!m_busy && (v0 || v1)) begin
        push_word(win, win ? bus0.req1_data : bus0.req0_data);
        m_busy = 1'b1;
        m_cnt  = '0;
`ifdef HAMMING_TX_RR_EN
        m_ptr  = !win;
`endif
      end else if (m_busy && bus0.tx_ready) begin
        if (m_cnt == 3'd7) m_busy = 1'b0;
        m_cnt = m_cnt + 3'd1;
      end
    end
  end

  task automatic send_word(input logic sel, input logic [63:0] d);
    logic ok;
    ok = 1'b0;
    if (sel) begin
      bus0.req1_data  = d;
      bus0.req1_valid = 1'b1;
    end else begin
      bus0.req0_data  = d;
      bus0.req0_valid = 1'b1;
    end
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = sel ? bus0.req1_ready : bus0.req0_ready;
    end
    @(posedge clk);
    #1;
    bus0.req0_valid = 1'b0;
    bus0.req1_valid = 1'b0;
    check_eq("accept_timeout", 64'(ok), 64'(1));
  endtask

  task automatic wait_idle();
    int unsigned n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((bus0.tx_valid || q0.size() != 0) && n < 200);
    check_eq("idle_timeout", 64'(n < 200), 64'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned hs;
    logic [63:0] d;
    bus0.req0_valid = 1'b1;
    bus0.req0_data  = 64'hFF;
    bus0.req1_valid = 1'b0;
    bus0.req1_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_ready0", 64'(bus0.req0_ready), 64'(0));
    check_eq("reset_tx_valid", 64'(bus0.tx_valid), 64'(0));
    check_eq("reset_tx_last", 64'(bus0.tx_last), 64'(0));
    check_eq("reset_tx_src", 64'(bus0.tx_src), 64'(0));
    check_eq("reset_busy", 64'(bus0.busy), 64'(0));
    bus0.req0_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single word from requester 0, LSB block first.
    log0.delete();
    log1.delete();
    send_word(1'b0, 64'h00000000000000FF);
    wait_idle();
    check_eq("w0_beats", 64'(log0.size()), 64'(8));
    if (log0.size() == 8) begin
      check_eq("w0_beat0", 64'(log0[0].data), 64'h7778);
      for (int i = 1; i < 8; i++) check_eq("w0_beat_zero", 64'(log0[i].data), 64'h0);
      for (int i = 0; i < 8; i++) check_eq("w0_last", 64'(log0[i].last), 64'(i == 7));
      check_eq("w0_src", 64'(log0[0].src), 64'(0));
    end

    // Requester 1, both block orders.
    log0.delete();
    log1.delete();
    send_word(1'b1, 64'h0000000000000001);
    wait_idle();
    check_eq("w1_beats", 64'(log0.size()), 64'(8));
    check_eq("w1_beats_m", 64'(log1.size()), 64'(8));
    if (log0.size() == 8 && log1.size() == 8) begin
      check_eq("w1_beat0", 64'(log0[0].data), 64'h8888);
      check_eq("w1_src", 64'(log0[0].src), 64'(1));
      check_eq("w1_m_beat0", 64'(log1[0].data), 64'h0);
      check_eq("w1_m_beat7", 64'(log1[7].data), 64'h8888);
    end

    // Random words with random backpressure.
    ready_mode = 2;
    for (int i = 0; i < 4; i++) begin
      d = {$urandom, $urandom};
      send_word(1'($urandom_range(0, 1)), d);
      wait_idle();
    end

    // 1,0,0,1 backpressure pattern.
    ready_mode = 1;
    log0.delete();
    send_word(1'b0, 64'hDEADBEEF01234567);
    wait_idle();
    ready_mode = 0;
    check_eq("stall_beats", 64'(log0.size()), 64'(8));

    // New request during the final beat handshake.
    send_word(1'b1, 64'hA5A5A5A5A5A5A5A5);
    hs = 0;
    while (!(bus0.tx_last && bus0.tx_ready) && hs < 50) begin
      @(negedge clk);
      hs++;
    end
    bus0.req0_data  = 64'h0F0F0F0F0F0F0F0F;
    bus0.req0_valid = 1'b1;
    #1;
    check_eq("ready_on_last", 64'(bus0.req0_ready), 64'(0));
    @(negedge clk);
    #1;
    check_eq("ready_after_last", 64'(bus0.req0_ready), 64'(1));
    @(posedge clk);
    #1;
    bus0.req0_valid = 1'b0;
    wait_idle();

    // Reset mid-codeword at beat 4.
    log0.delete();
    send_word(1'b0, 64'h0123456789ABCDEF);
    hs = 0;
    for (int i = 0; i < 50 && hs < 4; i++) begin
      @(negedge clk);
      if (bus0.tx_valid && bus0.tx_ready) hs++;
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_valid", 64'(bus0.tx_valid), 64'(0));
    check_eq("rst_mid_busy", 64'(bus0.busy), 64'(0));
    check_eq("rst_mid_valid_m", 64'(bus1.tx_valid), 64'(0));
    check_eq("rst_mid_beats", 64'(log0.size()), 64'(4));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    log0.delete();
    send_word(1'b1, 64'h1122334455667701);
    wait_idle();
    check_eq("post_rst_beats", 64'(log0.size()), 64'(8));
    if (log0.size() == 8) begin
      check_eq("post_rst_beat0", 64'(log0[0].data), 64'h8888);
      check_eq("post_rst_last7", 64'(log0[7].last), 64'(1));
    end

    // Both requesters held valid from a fresh reset.
    pulse_reset();
    glog.delete();
    bus0.req0_data  = 64'h1111111111111111;
    bus0.req1_data  = 64'h2222222222222222;
    bus0.req0_valid = 1'b1;
    bus0.req1_valid = 1'b1;
    for (int i = 0; i < 60 && glog.size() < 4; i++) @(negedge clk);
    @(posedge clk);
    #1;
    bus0.req0_valid = 1'b0;
    bus0.req1_valid = 1'b0;
    wait_idle();
    check_eq("grant_count", 64'(glog.size()), 64'(4));
    if (glog.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
`ifdef HAMMING_TX_RR_EN
        check_eq("grant_rr", 64'(glog[i]), 64'(i % 2));
`else
        check_eq("grant_fixed", 64'(glog[i]), 64'(0));
`endif
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
